register_file16: RTL and testbench
==================================

// Module: register_file16
// PURPOSE
//  - 8 x 16-bit general-purpose register file for the 16-bit MIPS datapath.
//  - Sits directly downstream of the write-back 2:1 16-bit mux (ALU result vs. memory data).
//    That mux output drives wr_data.
//  - Two combinational read ports feed the ALU operand muxes. One synchronous write port.
//  - R0 is hardwired to zero. Same-cycle write->read bypass.
// PARAMETERS
//  DATA_W   16  register width in bits
//  ADDR_W    3  register address width; depth = 2**ADDR_W = 8
// PORTS
//  clk       in   1       rising-edge clock
//  reset     in   1       asynchronous, active-high; clears all registers
//  wr_en     in   1       write enable, sampled on rising clk
//  wr_addr   in   ADDR_W  destination register
//  wr_data   in   DATA_W  write-back data (from write-back mux)
//  rd_addr_a in   ADDR_W  read port A address
//  rd_addr_b in   ADDR_W  read port B address
//  rd_data_a out  DATA_W  read port A data
//  rd_data_b out  DATA_W  read port B data
//  wr_count  out  8       count of committed writes, saturating, debug/coverage
// BEHAVIOUR
//  - Reset (async, active-high):
//    - All registers clear to 16'h0000 immediately, regardless of clk.
//    - wr_count clears to 8'h00.
//    - Reads during reset return 16'h0000.
//  - Write: on posedge clk with reset low, wr_en=1 and wr_addr!=0 -> regs[wr_addr] <= wr_data.
//    - Latency 1 cycle: the value is architecturally visible from the next cycle.
//    - wr_count increments by 1 on the same edge and saturates at 8'hFF.
//  - Writes to R0 are discarded and do not increment wr_count. R0 always reads 16'h0000.
//  - Read (combinational, 0 latency): rd_data_x = regs[rd_addr_x].
//  - Bypass: if wr_en=1, wr_addr!=0 and rd_addr_x==wr_addr, then rd_data_x = wr_data in the
//    same cycle, not the stale stored value.
//    - Both ports may bypass simultaneously.
//  - rd_addr_a == rd_addr_b is legal: both ports return the same data.
//  - Reset asserted mid-cycle while wr_en=1: reset wins and no write occurs.
//    On deassertion the first write takes effect at the next rising edge.
//  - wr_en=0: storage holds. wr_data/wr_addr are don't-care.
//  - X on wr_addr while wr_en=1 is illegal. The bench flags it with an assertion.
// STRUCTURE
//  - Shared package mips16_pkg: DATA_W=16, ADDR_W=3, NUM_REGS=8, REG_ZERO=3'd0.
//  - Sub-module reg16: DATA_W-bit register with async active-high reset and load enable.
//    Instantiated 7 times (R1..R7).
//  - Top level contains:
//    - 3:8 write decoder gated by wr_en.
//    - Two 8:1 read muxes.
//    - Per-port bypass compare.
//    - wr_count counter.
// TESTING
//  1. Assert reset with clk idle. Read all 8 addresses on both ports -> 16'h0000; wr_count=0.
//  2. Write R3=16'hBEEF. Next cycle rd_addr_a=3 -> 16'hBEEF; wr_count=1.
//  3. Write R0=16'hFFFF, then read R0 on A and B -> 16'h0000; wr_count unchanged.
//  4. wr_en=1, wr_addr=5, wr_data=16'h1234, rd_addr_a=rd_addr_b=5 in the same cycle:
//     both ports -> 16'h1234 before the edge.
//  5. Write R7=16'hA5A5. Assert reset mid-cycle with wr_en=1, wr_data=16'h5A5A, then release.
//     R7 reads 16'h0000 and no 16'h5A5A appears.
//  6. Perform 300 consecutive writes to R1..R7 -> wr_count saturates at 8'hFF.
//     R1..R7 hold their last written values.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared widths and constants for the 16-bit MIPS datapath register file.
package mips16_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 3;
    localparam int NUM_REGS   = 8;
    localparam int WR_COUNT_W = 8;

    localparam logic [ADDR_W-1:0]     REG_ZERO     = 3'd0;
    localparam logic [WR_COUNT_W-1:0] WR_COUNT_MAX = 8'hFF;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] val);
        if (val == WR_COUNT_MAX) begin
            return val;
        end
        return val + 1'b1;
    endfunction

endpackage

// File: rtl/register_file16_reg16.sv
// Load-enabled DATA_W-bit storage register with asynchronous active-high clear.
module reg16 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (ld_en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/register_file16.sv
// 8 x 16-bit register file: R0 hardwired to zero, two combinational read
// ports with same-cycle write bypass, one synchronous write port, write counter.
module register_file16
    import mips16_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic [WR_COUNT_W-1:0] wr_count
);

    logic [DATA_W-1:0]     reg_q [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_sel;
    logic                  wr_commit;
    logic [ADDR_W-1:0]     rd_addr [2];
    logic [DATA_W-1:0]     rd_data [2];
    logic [WR_COUNT_W-1:0] wr_count_q;
    logic [WR_COUNT_W-1:0] wr_count_d;

    assign wr_commit = wr_en && (wr_addr != REG_ZERO);

    assign reg_q[0]  = '0;
    assign wr_sel[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            assign wr_sel[gi] = wr_en && (wr_addr == ADDR_W'(gi));

            reg16 #(
                .DATA_W (DATA_W)
            ) u_reg (
                .clk   (clk),
                .reset (reset),
                .ld_en (wr_sel[gi]),
                .d     (wr_data),
                .q     (reg_q[gi])
            );
        end
    endgenerate

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    // Bypass is suppressed during reset so reads return zero even if wr_en is high.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd_port
            logic bypass_hit;

            assign bypass_hit = wr_commit && !reset && (rd_addr[gi] == wr_addr);

            always_comb begin
                rd_data[gi] = reg_q[rd_addr[gi]];
                if (bypass_hit) begin
                    rd_data[gi] = wr_data;
                end
            end
        end
    endgenerate

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_commit) begin
            wr_count_d = sat_inc(wr_count_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_register_file16.sv
// Directed bench for register_file16: reset, write, R0, bypass, mid-cycle reset, saturation.
module tb_register_file16;
    import mips16_pkg::*;

    logic                  clk;
    logic                  clk_run;
    logic                  reset;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [ADDR_W-1:0]     rd_addr_a;
    logic [ADDR_W-1:0]     rd_addr_b;
    logic [DATA_W-1:0]     rd_data_a;
    logic [DATA_W-1:0]     rd_data_b;
    logic [WR_COUNT_W-1:0] wr_count;

    int total;
    int bad;

    register_file16 dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    always @(posedge clk) begin
        if (!reset && wr_en === 1'b1) begin
            assert (!$isunknown(wr_addr)) else $error("wr_addr is X while wr_en=1");
        end
    end

    task automatic test_reset();
        logic [ADDR_W-1:0] a;
        #1 reset = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            a = ADDR_W'(i);
            rd_addr_a = a;
            rd_addr_b = a;
            #1;
            total++;
            if (rd_data_a !== 16'h0000) begin
                bad++;
                $display("FAIL reset_rd_a addr=%0d got=%h exp=0000", i, rd_data_a);
            end
            total++;
            if (rd_data_b !== 16'h0000) begin
                bad++;
                $display("FAIL reset_rd_b addr=%0d got=%h exp=0000", i, rd_data_b);
            end
        end
        total++;
        if (wr_count !== 8'h00) begin
            bad++;
            $display("FAIL reset_count got=%h exp=00", wr_count);
        end
        $display("reset: all addresses read while clock idle, wr_count=%h", wr_count);
        clk_run = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_addr_a = 3'd3; rd_addr_b = 3'd2;
        #1;
        total++;
        if (rd_data_a !== 16'hBEEF) begin
            bad++;
            $display("FAIL write_r3 got=%h exp=BEEF", rd_data_a);
        end
        total++;
        if (rd_data_b !== 16'h0000) begin
            bad++;
            $display("FAIL write_r2_untouched got=%h exp=0000", rd_data_b);
        end
        total++;
        if (wr_count !== 8'h01) begin
            bad++;
            $display("FAIL write_count got=%h exp=01", wr_count);
        end
        $display("write: R3<=BEEF, read=%h count=%h", rd_data_a, wr_count);
    endtask

    task automatic test_r0();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        #1;
        total++;
        if (rd_data_a !== 16'h0000) begin
            bad++;
            $display("FAIL r0_no_bypass got=%h exp=0000", rd_data_a);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        #1;
        total++;
        if (rd_data_a !== 16'h0000) begin
            bad++;
            $display("FAIL r0_rd_a got=%h exp=0000", rd_data_a);
        end
        total++;
        if (rd_data_b !== 16'h0000) begin
            bad++;
            $display("FAIL r0_rd_b got=%h exp=0000", rd_data_b);
        end
        total++;
        if (wr_count !== 8'h01) begin
            bad++;
            $display("FAIL r0_count got=%h exp=01", wr_count);
        end
        $display("r0: write FFFF discarded, reads %h/%h count=%h", rd_data_a, rd_data_b, wr_count);
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
        rd_addr_a = 3'd5; rd_addr_b = 3'd5;
        #1;
        total++;
        if (rd_data_a !== 16'h1234) begin
            bad++;
            $display("FAIL bypass_a got=%h exp=1234", rd_data_a);
        end
        total++;
        if (rd_data_b !== 16'h1234) begin
            bad++;
            $display("FAIL bypass_b got=%h exp=1234", rd_data_b);
        end
        rd_addr_b = 3'd3;
        #1;
        total++;
        if (rd_data_b !== 16'hBEEF) begin
            bad++;
            $display("FAIL bypass_other_port got=%h exp=BEEF", rd_data_b);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_addr_b = 3'd5;
        #1;
        total++;
        if (rd_data_a !== 16'h1234 || rd_data_b !== 16'h1234) begin
            bad++;
            $display("FAIL bypass_stored got=%h/%h exp=1234/1234", rd_data_a, rd_data_b);
        end
        total++;
        if (wr_count !== 8'h02) begin
            bad++;
            $display("FAIL bypass_count got=%h exp=02", wr_count);
        end
        $display("bypass: R5<=1234 visible same cycle on both ports, count=%h", wr_count);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hA5A5;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_addr_a = 3'd7;
        #1;
        total++;
        if (rd_data_a !== 16'hA5A5) begin
            bad++;
            $display("FAIL mid_pre_r7 got=%h exp=A5A5", rd_data_a);
        end
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h5A5A;
        #2 reset = 1'b1;
        #1;
        total++;
        if (rd_data_a !== 16'h0000) begin
            bad++;
            $display("FAIL mid_during_reset got=%h exp=0000", rd_data_a);
        end
        @(posedge clk); #1;
        total++;
        if (rd_data_a !== 16'h0000 || wr_count !== 8'h00) begin
            bad++;
            $display("FAIL mid_after_edge got=%h cnt=%h exp=0000 cnt=00", rd_data_a, wr_count);
        end
        @(negedge clk);
        wr_en = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rd_data_a !== 16'h0000 || wr_count !== 8'h00) begin
            bad++;
            $display("FAIL mid_release got=%h cnt=%h exp=0000 cnt=00", rd_data_a, wr_count);
        end
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1111;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_addr_b = 3'd2;
        #1;
        total++;
        if (rd_data_b !== 16'h1111 || wr_count !== 8'h01) begin
            bad++;
            $display("FAIL mid_first_write got=%h cnt=%h exp=1111 cnt=01", rd_data_b, wr_count);
        end
        $display("reset_mid: R7=%h after reset, first write R2=%h count=%h", rd_data_a, rd_data_b, wr_count);
    endtask

    task automatic test_saturate();
        logic [DATA_W-1:0] exp_reg [NUM_REGS];
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < NUM_REGS; k++) exp_reg[k] = 16'h0000;
        exp_reg[2] = 16'h1111;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a = ADDR_W'((i % 7) + 1);
            wr_en = 1'b1; wr_addr = a; wr_data = 16'(32'h1000 + i);
            exp_reg[a] = 16'(32'h1000 + i);
            @(posedge clk); #1;
            if (i == 99) begin
                total++;
                if (wr_count !== 8'd101) begin
                    bad++;
                    $display("FAIL sat_mid_count got=%0d exp=101", wr_count);
                end
            end
        end
        wr_en = 1'b0;
        #1;
        total++;
        if (wr_count !== 8'hFF) begin
            bad++;
            $display("FAIL sat_count got=%h exp=FF", wr_count);
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            a = ADDR_W'(k);
            rd_addr_a = a;
            rd_addr_b = a;
            #1;
            total++;
            if (rd_data_a !== exp_reg[k] || rd_data_b !== exp_reg[k]) begin
                bad++;
                $display("FAIL sat_reg r%0d got=%h/%h exp=%h", k, rd_data_a, rd_data_b, exp_reg[k]);
            end
        end
        $display("saturate: 300 writes, count=%h", wr_count);
    endtask

    initial begin
        total = 0; bad = 0;
        clk_run = 1'b0;
        reset = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        test_reset();
        test_write();
        test_r0();
        test_bypass();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
